// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single Common Data Bus.
// Grants at most one execution-unit result per cycle (combinational
// req_ready), registers the winner and broadcasts it as cdb_valid/
// cdb_result/cdb_tag/cdb_src the following cycle.
// Optional build macro CDB_ARB_LOAD_PRI_EN: requester 0 (load unit) gets
// fixed priority; the remaining requesters share a round-robin pointer
// that ranges over 1..NUM_REQ-1.
module cdb_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     cdb_valid,
    output logic [XLEN-1:0]          cdb_result,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [SRC_W-1:0]         cdb_src
);

`ifdef CDB_ARB_LOAD_PRI_EN
    // Requester 0 sits outside the rotation; pointer lives in 1..NUM_REQ-1.
    localparam int unsigned RR_BASE = 1;
`else
    localparam int unsigned RR_BASE = 0;
`endif
    localparam int unsigned RR_SPAN = NUM_REQ - RR_BASE;
    localparam int unsigned LAST    = NUM_REQ - 1;

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   gnt_idx;
    logic               xfer;
    logic [XLEN-1:0]    sel_data;
    logic [TAG_W-1:0]   sel_tag;

    // Priority search starting at rr_ptr; only req_valid and rr_ptr feed it.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
`ifdef CDB_ARB_LOAD_PRI_EN
        if (req_valid[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < RR_SPAN; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - RR_SPAN;
            end
            if (!found && req_valid[SRC_W'(idx)]) begin
                found                = 1'b1;
                grant[SRC_W'(idx)]   = 1'b1;
                gnt_idx              = SRC_W'(idx);
            end
        end
    end

    // Reset and flush both suppress the grant outright.
    always_comb begin
        req_ready = (rst || flush) ? '0 : grant;
        xfer      = |req_ready;
    end

    // One-hot AND-OR select of the winning payload.
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*XLEN +: XLEN];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Pointer advances past the winner; a fixed-priority load grant leaves it alone.
    always_comb begin
        ptr_nxt = rr_ptr;
        if (xfer) begin
`ifdef CDB_ARB_LOAD_PRI_EN
            if (gnt_idx != '0) begin
                ptr_nxt = (gnt_idx == SRC_W'(LAST)) ? SRC_W'(RR_BASE) : gnt_idx + SRC_W'(1);
            end
`else
            ptr_nxt = (gnt_idx == SRC_W'(LAST)) ? SRC_W'(RR_BASE) : gnt_idx + SRC_W'(1);
`endif
        end
    end

    // Pointer and broadcast registers; payload holds when nothing transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= SRC_W'(RR_BASE);
            cdb_valid  <= 1'b0;
            cdb_result <= '0;
            cdb_tag    <= '0;
            cdb_src    <= '0;
        end else begin
            rr_ptr    <= ptr_nxt;
            cdb_valid <= xfer;
            if (xfer) begin
                cdb_result <= sel_data;
                cdb_tag    <= sel_tag;
                cdb_src    <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter (NUM_REQ=4). Each row is one cycle:
// inputs driven just after the rising edge, outputs sampled on the falling edge.
module tb_cdb_arbiter;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SRC_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*XLEN-1:0]  req_data;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cdb_valid;
    logic [XLEN-1:0]          cdb_result;
    logic [TAG_W-1:0]         cdb_tag;
    logic [SRC_W-1:0]         cdb_src;

    cdb_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic [3:0] valid;
        logic [3:0] ready;   // expected grant this cycle
        logic       cv;      // expected cdb_valid this cycle
        logic [1:0] src;     // expected cdb_src (held value when cv=0)
        logic       zero;    // payload still at its reset value
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] data_tbl[4];
    logic [7:0]  tag_tbl[4];
    int          errors = 0;
    int          checks = 0;
    int          row    = -1;

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                                input logic [3:0] rd, input logic c,
                                input logic [1:0] s, input logic z);
        vec_t t;
        t.rst = r; t.flush = f; t.valid = v; t.ready = rd;
        t.cv = c; t.src = s; t.zero = z;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic check_row(input vec_t t);
        logic [31:0] exp_data;
        logic [7:0]  exp_tag;
        exp_data = t.zero ? 32'h0 : data_tbl[t.src];
        exp_tag  = t.zero ? 8'h0  : tag_tbl[t.src];
        check("req_ready",  64'(req_ready),  64'(t.ready));
        check("cdb_valid",  64'(cdb_valid),  64'(t.cv));
        check("cdb_src",    64'(cdb_src),    64'(t.src));
        check("cdb_result", 64'(cdb_result), 64'(exp_data));
        check("cdb_tag",    64'(cdb_tag),    64'(exp_tag));
    endtask

    initial begin
        data_tbl[0] = 32'h1111_0000; tag_tbl[0] = 8'h10;
        data_tbl[1] = 32'h2222_0001; tag_tbl[1] = 8'h21;
        data_tbl[2] = 32'hDEAD_BEEF; tag_tbl[2] = 8'h2A;
        data_tbl[3] = 32'h4444_0003; tag_tbl[3] = 8'h43;

`ifdef CDB_ARB_LOAD_PRI_EN
        // Load unit wins while valid, then 1,2,3,1 with the pointer wrapping to 1.
        vecs.push_back(mk(0, 0, 4'b1111, 4'b0001, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 4'b1111, 4'b0001, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 4'b0001, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b1110, 4'b0010, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b1110, 4'b0100, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b1110, 4'b1000, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b1110, 4'b0010, 1, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 2'd1, 0));
`else
        // Single request from 2, one-cycle broadcast, then hold.
        vecs.push_back(mk(0, 0, 4'b0100, 4'b0100, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 2'd2, 0));
        // Reset, then all four valid: grants 0,1,2,3 back to back.
        vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 4'b0001, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 4'b1110, 4'b0010, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b1100, 4'b0100, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b1000, 4'b1000, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 2'd3, 0));
        // Grants 0,1,2 bring the pointer to 3; then 1001 wraps 3 -> 0.
        vecs.push_back(mk(0, 0, 4'b0111, 4'b0001, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0110, 4'b0010, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b0100, 4'b0100, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b1001, 4'b1000, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 4'b0001, 1, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0));
        // Pointer now 1: grant 1, flush next cycle, pointer stays at 2.
        vecs.push_back(mk(0, 0, 4'b0110, 4'b0010, 0, 2'd0, 0));
        vecs.push_back(mk(0, 1, 4'b0100, 4'b0000, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b0110, 4'b0100, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b0010, 4'b0010, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd1, 0));
        // Reset mid-stream with requests pending.
        vecs.push_back(mk(0, 0, 4'b1110, 4'b0100, 0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 4'b1010, 4'b0000, 1, 2'd2, 0));
        vecs.push_back(mk(0, 0, 4'b1010, 4'b0010, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 4'b1000, 4'b1000, 1, 2'd1, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 2'd3, 0));
        // Reset and flush together: reset wins.
        vecs.push_back(mk(1, 1, 4'b0001, 4'b0000, 0, 2'd3, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 4'b0001, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
`endif

        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {data_tbl[3], data_tbl[2], data_tbl[1], data_tbl[0]};
        req_tag   = {tag_tbl[3], tag_tbl[2], tag_tbl[1], tag_tbl[0]};

        // Reset state, with all requests valid to show req_ready is gated.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_row(mk(1, 0, 4'b1111, 4'b0000, 0, 2'd0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            row       = i;
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            req_valid = vecs[i].valid;
            @(negedge clk);
            check_row(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
